udp_pkt_buf_ctrl: RTL

UDP_PKT_BUF_CTRL -- requirements
Module: udp_pkt_buf_ctrl

---
 rtl/udp_pkt_buf_ctrl_if.sv | 29 ++
 rtl/udp_pkt_buf_ctrl.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/udp_pkt_buf_ctrl_if.sv
// Byte-stream bus for the packet buffer: a write-side strobe stream and a
// read-side valid/ready stream.
//
// Handshake: the write side has no back-pressure, so a byte is presented
// whenever in_valid is high. On the read side a byte moves only in a cycle
// where out_valid and out_ready are both high. Once out_valid is raised, it
// stays high and out_data/out_last hold steady until that transfer happens.
interface udp_pkt_buf_ctrl_if;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_last;
    logic       in_err;
    logic       out_valid;
    logic [7:0] out_data;
    logic       out_last;
    logic       out_ready;

    // The buffer controller side.
    modport slave (
        input  in_valid, in_data, in_last, in_err, out_ready,
        output out_valid, out_data, out_last
    );

    // The producer/consumer side.
    modport master (
        output in_valid, in_data, in_last, in_err, out_ready,
        input  out_valid, out_data, out_last
    );
endinterface

// File: rtl/udp_pkt_buf_ctrl.sv
// Store-and-forward packet buffer controller driving an external dual-port RAM.
// Bytes are written tentatively and become readable only when the packet
// commits on a good last byte. Errored packets are rewound. Packets that
// run out of space are discarded until their last byte arrives. The read side
// prefetches into a 2-entry output buffer so it can sustain one byte per cycle.
module udp_pkt_buf_ctrl #(
    parameter int ADDR_W = 11,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    udp_pkt_buf_ctrl_if.slave bus,
    output logic [ADDR_W-1:0] ram_addra,
    output logic [8:0]        ram_dia,
    output logic              ram_wea,
    output logic              ram_cea,
    output logic [ADDR_W-1:0] ram_addrb,
    output logic              ram_ceb,
    input  logic [8:0]        ram_dob,
    output logic [ADDR_W:0]   pkt_cnt,
    output logic [CNT_W-1:0]  drop_cnt,
    output logic [CNT_W-1:0]  ovf_cnt,
    output logic [1:0]        dbg_state,
    output logic [ADDR_W:0]   dbg_wr_ptr
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WRITE   = 2'd1,
        ST_DISCARD = 2'd2
    } wr_state_e;

    wr_state_e        state_q, state_d;
    logic [ADDR_W:0]  wr_ptr_q, wr_ptr_d;
    logic [ADDR_W:0]  wr_cmt_q, wr_cmt_d;
    logic [ADDR_W:0]  rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0]  fill;
    logic             space;
    logic             wr_en, commit, drop_ev, ovf_ev;

    logic             inflight_q;
    logic             pop, rd_issue;
    logic [1:0]       cnt_q, keep, occ;
    logic [8:0]       b0_q, b0_d, b1_q, b1_d;

    logic [ADDR_W:0]  pkt_cnt_q, pkt_cnt_d;
    logic [CNT_W-1:0] drop_q, drop_d, ovf_q, ovf_d;

    // Pointers carry one extra wrap bit. The difference can never exceed the
    // depth, so its top bit alone tells whether the RAM is full.
    assign fill  = wr_ptr_q - rd_ptr_q;
    assign space = ~fill[ADDR_W];

    // Write FSM: tentative write, commit on a good last byte, rewind on error
    // or overflow.
    always_comb begin
        state_d  = state_q;
        wr_ptr_d = wr_ptr_q;
        wr_cmt_d = wr_cmt_q;
        wr_en    = 1'b0;
        commit   = 1'b0;
        drop_ev  = 1'b0;
        ovf_ev   = 1'b0;
        case (state_q)
            ST_IDLE, ST_WRITE: begin
                if (bus.in_valid) begin
                    if (space) begin
                        wr_en    = 1'b1;
                        wr_ptr_d = wr_ptr_q + 1'b1;
                        if (bus.in_last) begin
                            state_d = ST_IDLE;
                            if (bus.in_err) begin
                                wr_ptr_d = wr_cmt_q;
                                drop_ev  = 1'b1;
                            end else begin
                                wr_cmt_d = wr_ptr_q + 1'b1;
                                commit   = 1'b1;
                            end
                        end else begin
                            state_d = ST_WRITE;
                        end
                    end else begin
                        // Out of room: throw away the partial packet.
                        wr_ptr_d = wr_cmt_q;
                        if (bus.in_last) begin
                            ovf_ev  = 1'b1;
                            state_d = ST_IDLE;
                        end else begin
                            state_d = ST_DISCARD;
                        end
                    end
                end
            end
            ST_DISCARD: begin
                if (bus.in_valid && bus.in_last) begin
                    ovf_ev  = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Read side: prefetch committed bytes whenever the output buffer will
    // still have room after this cycle's pop and any read already in flight.
    always_comb begin
        pop      = (cnt_q != 2'd0) && bus.out_ready;
        keep     = cnt_q - {1'b0, pop};
        occ      = keep + {1'b0, inflight_q};
        rd_issue = rst_n && (rd_ptr_q != wr_cmt_q) && (occ < 2'd2);
        rd_ptr_d = rd_ptr_q + {{ADDR_W{1'b0}}, rd_issue};
    end

    // Output buffer: shift on pop, then land the returning RAM byte just
    // behind whatever remains.
    always_comb begin
        b0_d = b0_q;
        b1_d = b1_q;
        if (pop) begin
            b0_d = b1_q;
        end
        if (inflight_q) begin
            if (keep == 2'd0) begin
                b0_d = ram_dob;
            end else begin
                b1_d = ram_dob;
            end
        end
    end

    // Packet count and saturating drop counters.
    always_comb begin
        pkt_cnt_d = pkt_cnt_q + {{ADDR_W{1'b0}}, commit}
                              - {{ADDR_W{1'b0}}, pop & b0_q[8]};
        drop_d    = (drop_ev && (drop_q != {CNT_W{1'b1}})) ? drop_q + 1'b1 : drop_q;
        ovf_d     = (ovf_ev && (ovf_q != {CNT_W{1'b1}})) ? ovf_q + 1'b1 : ovf_q;
    end

    // Write FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Pointers and counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q  <= '0;
            wr_cmt_q  <= '0;
            rd_ptr_q  <= '0;
            pkt_cnt_q <= '0;
            drop_q    <= '0;
            ovf_q     <= '0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            wr_cmt_q  <= wr_cmt_d;
            rd_ptr_q  <= rd_ptr_d;
            pkt_cnt_q <= pkt_cnt_d;
            drop_q    <= drop_d;
            ovf_q     <= ovf_d;
        end
    end

    // Output buffer registers and the in-flight read flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inflight_q <= 1'b0;
            cnt_q      <= 2'd0;
            b0_q       <= '0;
            b1_q       <= '0;
        end else begin
            inflight_q <= rd_issue;
            cnt_q      <= occ;
            b0_q       <= b0_d;
            b1_q       <= b1_d;
        end
    end

    assign ram_addra     = wr_ptr_q[ADDR_W-1:0];
    assign ram_dia       = {bus.in_last, bus.in_data};
    assign ram_wea       = wr_en & rst_n;
    assign ram_cea       = wr_en & rst_n;
    assign ram_addrb     = rd_ptr_q[ADDR_W-1:0];
    assign ram_ceb       = rd_issue;
    assign bus.out_valid = (cnt_q != 2'd0);
    assign bus.out_data  = b0_q[7:0];
    assign bus.out_last  = b0_q[8];
    assign pkt_cnt       = pkt_cnt_q;
    assign drop_cnt      = drop_q;
    assign ovf_cnt       = ovf_q;
    assign dbg_state     = state_q;
    assign dbg_wr_ptr    = wr_ptr_q;

endmodule
